// File: rtl/unified_mem_arbiter.sv
// Round-robin arbiter sharing the unified memory port between the core and the
// boot/debug loader: one transaction in flight, variable-latency handshake, timeout abort.
module unified_mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  output logic          core_ack,
  output logic          core_stall,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic [DW-1:0] ldr_rdata,
  output logic          ldr_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          grant_ldr,
  output logic          timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  logic          last_ldr;   // 1 = loader won the previous grant
  logic [CW-1:0] cnt;
  logic          pick_ldr;

  // Loader wins when it is alone, or on a conflict when the core was served last.
  always_comb begin
    pick_ldr = ldr_req & (~core_req | ~last_ldr);
  end

  assign core_stall = core_req & ~core_ack;

  // NOTE: non-blocking assignments so every register sees the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last_ldr    <= 1'b1;
      cnt         <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      core_rdata  <= '0;
      ldr_rdata   <= '0;
      core_ack    <= 1'b0;
      ldr_ack     <= 1'b0;
      grant_ldr   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (core_req | ldr_req) begin
            grant_ldr <= pick_ldr;
            last_ldr  <= pick_ldr;
            mem_req   <= 1'b1;
            mem_we    <= pick_ldr ? ldr_we    : core_we;
            mem_addr  <= pick_ldr ? ldr_addr  : core_addr;
            mem_wdata <= pick_ldr ? ldr_wdata : core_wdata;
            cnt       <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ready || cnt == CNT_LAST) begin
            // mem_we still carries the latched direction while in BUSY.
            if (!mem_ready) begin
              timeout_err <= 1'b1;
              if (grant_ldr) ldr_rdata  <= '0;
              else           core_rdata <= '0;
            end else if (!mem_we) begin
              if (grant_ldr) ldr_rdata  <= mem_rdata;
              else           core_rdata <= mem_rdata;
            end
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (grant_ldr) ldr_ack  <= 1'b1;
            else           core_ack <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          core_ack <= 1'b0;
          ldr_ack  <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
